mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares the single unified instruction/data memory port between two requesters. Requester 0 is the multi-cycle CPU control path (IF fetches and MEM-state LW/SW). Requester 1 is the program loader/DMA engine.
- Round-robin arbitration, one access in flight at a time.
- Registered memory-side handshake with variable latency and a timeout.
- Sits between the CPU datapath's memory mux (lorD address select) and the memory model.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT, 64, max cycles waiting for mem_ready before aborting (>=2)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
r0_req  in  1  CPU access request; held with r0_we/r0_addr/r0_wdata stable until r0_done or r0_err
r0_we  in  1  1 = write, 0 = read
r0_addr  in  ADDR_W  byte address
r0_wdata  in  DATA_W  write data
r0_done  out  1  one-cycle pulse: access completed
r0_err  out  1  one-cycle pulse: access timed out
r1_req, r1_we, r1_addr, r1_wdata, r1_done, r1_err  same as r0_*, for loader/DMA
rdata  out  DATA_W  read data, valid in the done-pulse cycle, held until the next done
gnt_id  out  1  requester owning the port (meaningful while busy=1)
busy  out  1  access in flight (state ACCESS or DONE)
mem_req  out  1  memory request, held high through ACCESS
mem_we  out  1  memory write enable, qualified by mem_req
mem_addr  out  ADDR_W  latched address
mem_wdata  out  DATA_W  latched write data
mem_rdata  in  DATA_W  memory read data, valid with mem_ready
mem_ready  in  1  memory completes the current access this cycle

Behaviour:
- Reset (reset=0, async): state=IDLE. All outputs 0, including rdata, gnt_id, busy. last_gnt=1, so requester 0 wins the first tie. Timeout counter=0.
- Reset asserted mid-access: access is abandoned with no done/err pulse. mem_req drops immediately.
- All outputs are registered; no combinational path from inputs to outputs.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If exactly one req is high, grant it.
  - If both are high, grant the one that is not last_gnt.
  - On grant: latch we/addr/wdata, set gnt_id, busy=1, mem_req=1, last_gnt=winner, counter=0; go to ACCESS.
  - No req: stay in IDLE.
- ACCESS:
  - mem_req=1; mem_we/addr/wdata stay constant.
  - mem_ready=1: on a read, latch mem_rdata into rdata. Drop mem_req, pulse rX_done for gnt_id next cycle; go to DONE.
  - mem_ready=0: counter+1. When counter reaches TIMEOUT-1 with mem_ready still 0, drop mem_req and pulse rX_err next cycle; go to DONE. rdata is unchanged.
  - mem_ready in the same cycle the counter hits its limit: completion wins (done, not err).
- DONE: done/err pulse visible for exactly this cycle. busy=1. Next state is IDLE, where busy=0.
- Latency: req sampled in IDLE at cycle 0 → mem_req=1 in cycle 1. mem_ready first sampled in cycle 1. With mem_ready=1 in cycle 1, done=1 in cycle 2 and a new grant is possible in cycle 3. Minimum 3 cycles per access.
- Requester drops req during ACCESS: the access still completes and done still pulses; writes are never cancelled.
- Requester still holds req after its done: it is treated as a new request. Round-robin guarantees the other side gets the next slot if it is waiting.
- Address and data pass through unmodified; no alignment checks.
- Counter width is clog2(TIMEOUT); it saturates rather than wraps.

Decomposition:
- Shared header (alongside the existing opcode/state define file):
  - state encodings ARB_IDLE=2'b00, ARB_ACCESS=2'b01, ARB_DONE=2'b10
  - requester IDs REQ_CPU=1'b0, REQ_DMA=1'b1
- One sub-module: rr_pick2. Purely combinational two-way round-robin picker with inputs req[1:0] and last and outputs valid and winner. It is reused by later arbiters.
- Timeout counter stays inline.

Test Plan:
- Single read, zero wait: r0_req=1, r0_we=0, r0_addr=0x10; mem_ready=1 in the first ACCESS cycle with mem_rdata=0xDEADBEEF → mem_req high for 1 cycle, r0_done at cycle 2, rdata=0xDEADBEEF, r1_done never.
- Simultaneous requests after reset: r0 and r1 both request, mem_ready=1 each time → r0 served first, then r1, then r0. gnt_id sequence 0,1,0; no back-to-back starvation.
- Wait states: r1 write, addr=0x200, wdata=0x12345678, mem_ready delayed 5 cycles → mem_req high for 6 cycles with addr/wdata/we constant; single r1_done pulse; rdata unchanged.
- Timeout: TIMEOUT=8, mem_ready held 0 → mem_req drops after 8 ACCESS cycles, r0_err pulses once, r0_done stays 0. Variant with mem_ready=1 on the limit cycle → r0_done, not err.
- Requester withdrawal: r0 drops req one cycle into ACCESS → access completes and r0_done still pulses. A pending r1 is granted in the following IDLE.
- Async reset mid-access: assert reset (low) between clock edges during ACCESS → mem_req, busy and gnt_id go to 0 immediately with no done/err. After release, the first simultaneous request goes to r0.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_pkg
// Description : Shared encodings for the unified memory port arbiter:
//               arbiter FSM states and requester identifiers.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

    // Arbiter FSM state encodings
    typedef enum logic [1:0] {
        ARB_IDLE   = 2'b00,
        ARB_ACCESS = 2'b01,
        ARB_DONE   = 2'b10
    } arb_state_t;

    // Requester identifiers, as reported on gnt_id
    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DMA = 1'b1;

endpackage : mem_port_arbiter_pkg
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Bundle of the two requester handshakes plus the memory-side
//               handshake. The slave modport is the arbiter's view; the
//               master modport is the environment's view (requesters and
//               memory model).
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Requester 0 (CPU control path)
    logic              r0_req;
    logic              r0_we;
    logic [ADDR_W-1:0] r0_addr;
    logic [DATA_W-1:0] r0_wdata;
    logic              r0_done;
    logic              r0_err;
    // Requester 1 (loader / DMA)
    logic              r1_req;
    logic              r1_we;
    logic [ADDR_W-1:0] r1_addr;
    logic [DATA_W-1:0] r1_wdata;
    logic              r1_done;
    logic              r1_err;
    // Shared status
    logic [DATA_W-1:0] rdata;
    logic              gnt_id;
    logic              busy;
    // Memory side
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport slave (
        input  r0_req, r0_we, r0_addr, r0_wdata,
        input  r1_req, r1_we, r1_addr, r1_wdata,
        input  mem_rdata, mem_ready,
        output r0_done, r0_err, r1_done, r1_err,
        output rdata, gnt_id, busy,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output r0_req, r0_we, r0_addr, r0_wdata,
        output r1_req, r1_we, r1_addr, r1_wdata,
        output mem_rdata, mem_ready,
        input  r0_done, r0_err, r1_done, r1_err,
        input  rdata, gnt_id, busy,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface : mem_port_arbiter_if
`default_nettype wire

// File: rtl/mem_port_arbiter_rr_pick2.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick2
// Description : Combinational two-way round-robin picker. On a tie the
//               requester that did not win last time is chosen.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick2 (
    input  wire logic [1:0] req,
    input  wire logic       last,
    output logic            valid,
    output logic            winner
);

    // Tie goes to the side that did not win last; otherwise the lone requester
    always_comb begin
        valid  = |req;
        winner = (req == 2'b11) ? ~last : req[1];
    end

endmodule : rr_pick2
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Round-robin arbiter sharing one memory port between the CPU
//               control path (requester 0) and the loader/DMA (requester 1).
//               One access in flight, registered outputs, memory timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  wire logic           clk,
    input  wire logic           reset,
    mem_port_arbiter_if.slave   bus
);

    localparam int               CNT_W     = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT - 1);

    arb_state_t        r_state,     w_state_nxt;
    logic              r_last_gnt,  w_last_nxt;
    logic              r_gnt_id,    w_gnt_nxt;
    logic              r_we,        w_we_nxt;
    logic [ADDR_W-1:0] r_addr,      w_addr_nxt;
    logic [DATA_W-1:0] r_wdata,     w_wdata_nxt;
    logic [DATA_W-1:0] r_rdata,     w_rdata_nxt;
    logic [CNT_W-1:0]  r_cnt,       w_cnt_nxt;
    logic [1:0]        r_done,      w_done_nxt;
    logic [1:0]        r_err,       w_err_nxt;
    logic              r_busy,      w_busy_nxt;
    logic              r_mem_req,   w_mem_req_nxt;
    logic              r_mem_we,    w_mem_we_nxt;

    logic              w_pick_valid;
    logic              w_pick_winner;

    rr_pick2 u_pick (
        .req    ({bus.r1_req, bus.r0_req}),
        .last   (r_last_gnt),
        .valid  (w_pick_valid),
        .winner (w_pick_winner)
    );

    // State and output registers; reset abandons any access without a pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ARB_IDLE;
            r_last_gnt <= REQ_DMA;
            r_gnt_id   <= REQ_CPU;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_cnt      <= '0;
            r_done     <= 2'b00;
            r_err      <= 2'b00;
            r_busy     <= 1'b0;
            r_mem_req  <= 1'b0;
            r_mem_we   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_last_gnt <= w_last_nxt;
            r_gnt_id   <= w_gnt_nxt;
            r_we       <= w_we_nxt;
            r_addr     <= w_addr_nxt;
            r_wdata    <= w_wdata_nxt;
            r_rdata    <= w_rdata_nxt;
            r_cnt      <= w_cnt_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
            r_busy     <= w_busy_nxt;
            r_mem_req  <= w_mem_req_nxt;
            r_mem_we   <= w_mem_we_nxt;
        end
    end

    // Next-state and next-output logic; completion takes priority over timeout
    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last_gnt;
        w_gnt_nxt   = r_gnt_id;
        w_we_nxt    = r_we;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_rdata_nxt = r_rdata;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 2'b00;
        w_err_nxt   = 2'b00;

        case (r_state)
            ARB_IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt = ARB_ACCESS;
                    w_gnt_nxt   = w_pick_winner;
                    w_last_nxt  = w_pick_winner;
                    w_we_nxt    = w_pick_winner ? bus.r1_we    : bus.r0_we;
                    w_addr_nxt  = w_pick_winner ? bus.r1_addr  : bus.r0_addr;
                    w_wdata_nxt = w_pick_winner ? bus.r1_wdata : bus.r0_wdata;
                    w_cnt_nxt   = '0;
                end
            end
            ARB_ACCESS: begin
                if (bus.mem_ready) begin
                    if (!r_we) begin
                        w_rdata_nxt = bus.mem_rdata;
                    end
                    w_done_nxt[r_gnt_id] = 1'b1;
                    w_state_nxt          = ARB_DONE;
                end else if (r_cnt == CNT_LIMIT) begin
                    w_err_nxt[r_gnt_id] = 1'b1;
                    w_state_nxt         = ARB_DONE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ARB_DONE: begin
                w_state_nxt = ARB_IDLE;
            end
            default: begin
                w_state_nxt = ARB_IDLE;
            end
        endcase

        w_busy_nxt    = (w_state_nxt != ARB_IDLE);
        w_mem_req_nxt = (w_state_nxt == ARB_ACCESS);
        w_mem_we_nxt  = w_we_nxt & w_mem_req_nxt;
    end

    assign bus.r0_done   = r_done[0];
    assign bus.r1_done   = r_done[1];
    assign bus.r0_err    = r_err[0];
    assign bus.r1_err    = r_err[1];
    assign bus.rdata     = r_rdata;
    assign bus.gnt_id    = r_gnt_id;
    assign bus.busy      = r_busy;
    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter (TIMEOUT = 8).
//               Cycle-by-cycle vector table plus hand-written sequences for
//               wait states, timeout, withdrawal and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        r0_req;
        logic        r0_we;
        logic [31:0] r0_addr;
        logic [31:0] r0_wdata;
        logic        r1_req;
        logic        r1_we;
        logic [31:0] r1_addr;
        logic [31:0] r1_wdata;
        logic        mem_ready;
        logic [31:0] mem_rdata;
        logic        e_busy;
        logic        e_gnt;
        logic        e_mreq;
        logic        e_mwe;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [1:0]  e_done;
        logic [1:0]  e_err;
        logic [31:0] e_rdata;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.r0_req = 1'b0; bus.r0_we = 1'b0; bus.r0_addr = '0; bus.r0_wdata = '0;
        bus.r1_req = 1'b0; bus.r1_we = 1'b0; bus.r1_addr = '0; bus.r1_wdata = '0;
        bus.mem_ready = 1'b0; bus.mem_rdata = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One access by a single requester; memory answers on the ready_at-th
    // ACCESS cycle (0 = never). Counts mem_req cycles and pulses.
    task automatic do_access(input bit id, input bit we, input logic [31:0] addr,
                             input logic [31:0] wdata, input int ready_at,
                             input logic [31:0] rd,
                             output int n_req, output int n_done, output int n_err,
                             output int n_other, output int n_bad_hold);
        n_req = 0; n_done = 0; n_err = 0; n_other = 0; n_bad_hold = 0;
        clear_inputs();
        if (id) begin
            bus.r1_req = 1'b1; bus.r1_we = we; bus.r1_addr = addr; bus.r1_wdata = wdata;
        end else begin
            bus.r0_req = 1'b1; bus.r0_we = we; bus.r0_addr = addr; bus.r0_wdata = wdata;
        end
        for (int c = 0; c < 16; c++) begin
            step();
            if (bus.mem_req) begin
                n_req++;
                if (bus.mem_addr !== addr || bus.mem_wdata !== wdata ||
                    bus.mem_we !== we || bus.gnt_id !== id)
                    n_bad_hold++;
            end
            if (id) begin
                n_done  += int'(bus.r1_done);
                n_err   += int'(bus.r1_err);
                n_other += int'(bus.r0_done) + int'(bus.r0_err);
            end else begin
                n_done  += int'(bus.r0_done);
                n_err   += int'(bus.r0_err);
                n_other += int'(bus.r1_done) + int'(bus.r1_err);
            end
            if (bus.r0_done || bus.r0_err || bus.r1_done || bus.r1_err) begin
                bus.r0_req = 1'b0;
                bus.r1_req = 1'b0;
            end
            bus.mem_ready = bus.mem_req && (n_req == ready_at);
            bus.mem_rdata = rd;
        end
        bus.mem_ready = 1'b0;
    endtask

    // Grant requester id, then assert reset between clock edges mid-access
    task automatic reset_mid(input bit id);
        int pulses;
        clear_inputs();
        if (id) bus.r1_req = 1'b1; else bus.r0_req = 1'b1;
        step();
        check($sformatf("rstmid%0d gnt before", id), 32'(bus.gnt_id), 32'(id));
        check($sformatf("rstmid%0d mem_req before", id), 32'(bus.mem_req), 32'h1);
        clear_inputs();
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check($sformatf("rstmid%0d mem_req", id), 32'(bus.mem_req), 32'h0);
        check($sformatf("rstmid%0d busy", id), 32'(bus.busy), 32'h0);
        check($sformatf("rstmid%0d gnt_id", id), 32'(bus.gnt_id), 32'h0);
        pulses = 0;
        repeat (2) begin
            step();
            pulses += int'(bus.r0_done) + int'(bus.r0_err) + int'(bus.r1_done) + int'(bus.r1_err);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (2) begin
            step();
            pulses += int'(bus.r0_done) + int'(bus.r0_err) + int'(bus.r1_done) + int'(bus.r1_err);
        end
        check($sformatf("rstmid%0d no pulses", id), 32'(pulses), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int n_req, n_done, n_err, n_other, n_bad;

        //            r0 req/we/addr/wdata                r1 req/we/addr/wdata                rdy   mem_rdata       busy  gnt   mreq  mwe   maddr     mwdata    done   err    rdata
        vecs[0]  = '{1'b1,1'b0,32'h10,32'h0,           1'b0,1'b0,32'h0, 32'h0,           1'b0, 32'h0,          1'b1, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 2'b00, 2'b00, 32'h0};
        vecs[1]  = '{1'b1,1'b0,32'h10,32'h0,           1'b0,1'b0,32'h0, 32'h0,           1'b1, 32'hDEADBEEF,   1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 2'b01, 2'b00, 32'hDEADBEEF};
        vecs[2]  = '{1'b0,1'b0,32'h0, 32'h0,           1'b0,1'b0,32'h0, 32'h0,           1'b0, 32'h0,          1'b0, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 2'b00, 2'b00, 32'hDEADBEEF};
        vecs[3]  = '{1'b1,1'b1,32'h20,32'hA,           1'b1,1'b0,32'h30,32'hB,           1'b0, 32'h0,          1'b1, 1'b1, 1'b1, 1'b0, 32'h30, 32'hB, 2'b00, 2'b00, 32'hDEADBEEF};
        vecs[4]  = '{1'b1,1'b1,32'h20,32'hA,           1'b1,1'b0,32'h30,32'hB,           1'b1, 32'h11111111,   1'b1, 1'b1, 1'b0, 1'b0, 32'h30, 32'hB, 2'b10, 2'b00, 32'h11111111};
        vecs[5]  = '{1'b1,1'b1,32'h20,32'hA,           1'b1,1'b0,32'h30,32'hB,           1'b0, 32'h0,          1'b0, 1'b1, 1'b0, 1'b0, 32'h30, 32'hB, 2'b00, 2'b00, 32'h11111111};
        vecs[6]  = '{1'b1,1'b1,32'h20,32'hA,           1'b1,1'b0,32'h30,32'hB,           1'b0, 32'h0,          1'b1, 1'b0, 1'b1, 1'b1, 32'h20, 32'hA, 2'b00, 2'b00, 32'h11111111};
        vecs[7]  = '{1'b1,1'b1,32'h20,32'hA,           1'b1,1'b0,32'h30,32'hB,           1'b1, 32'h22222222,   1'b1, 1'b0, 1'b0, 1'b0, 32'h20, 32'hA, 2'b01, 2'b00, 32'h11111111};
        vecs[8]  = '{1'b0,1'b0,32'h0, 32'h0,           1'b1,1'b0,32'h30,32'hB,           1'b0, 32'h0,          1'b0, 1'b0, 1'b0, 1'b0, 32'h20, 32'hA, 2'b00, 2'b00, 32'h11111111};
        vecs[9]  = '{1'b0,1'b0,32'h0, 32'h0,           1'b1,1'b0,32'h30,32'hB,           1'b0, 32'h0,          1'b1, 1'b1, 1'b1, 1'b0, 32'h30, 32'hB, 2'b00, 2'b00, 32'h11111111};
        vecs[10] = '{1'b0,1'b0,32'h0, 32'h0,           1'b1,1'b0,32'h30,32'hB,           1'b1, 32'h33333333,   1'b1, 1'b1, 1'b0, 1'b0, 32'h30, 32'hB, 2'b10, 2'b00, 32'h33333333};
        vecs[11] = '{1'b0,1'b0,32'h0, 32'h0,           1'b0,1'b0,32'h0, 32'h0,           1'b0, 32'h0,          1'b0, 1'b1, 1'b0, 1'b0, 32'h30, 32'hB, 2'b00, 2'b00, 32'h33333333};

        // Reset state
        clear_inputs();
        reset = 1'b1;
        #1;
        reset = 1'b0;
        #2;
        check("reset busy",     32'(bus.busy),    32'h0);
        check("reset mem_req",  32'(bus.mem_req), 32'h0);
        check("reset mem_we",   32'(bus.mem_we),  32'h0);
        check("reset gnt_id",   32'(bus.gnt_id),  32'h0);
        check("reset rdata",    bus.rdata,        32'h0);
        check("reset mem_addr", bus.mem_addr,     32'h0);
        check("reset pulses",   32'({bus.r0_done, bus.r0_err, bus.r1_done, bus.r1_err}), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        step();

        // Table: single zero-wait read, then round-robin under contention
        for (int i = 0; i < NV; i++) begin
            bus.r0_req = vecs[i].r0_req;  bus.r0_we = vecs[i].r0_we;
            bus.r0_addr = vecs[i].r0_addr; bus.r0_wdata = vecs[i].r0_wdata;
            bus.r1_req = vecs[i].r1_req;  bus.r1_we = vecs[i].r1_we;
            bus.r1_addr = vecs[i].r1_addr; bus.r1_wdata = vecs[i].r1_wdata;
            bus.mem_ready = vecs[i].mem_ready; bus.mem_rdata = vecs[i].mem_rdata;
            step();
            check($sformatf("v%0d busy", i),      32'(bus.busy),     32'(vecs[i].e_busy));
            check($sformatf("v%0d gnt_id", i),    32'(bus.gnt_id),   32'(vecs[i].e_gnt));
            check($sformatf("v%0d mem_req", i),   32'(bus.mem_req),  32'(vecs[i].e_mreq));
            check($sformatf("v%0d mem_we", i),    32'(bus.mem_we),   32'(vecs[i].e_mwe));
            check($sformatf("v%0d mem_addr", i),  bus.mem_addr,      vecs[i].e_addr);
            check($sformatf("v%0d mem_wdata", i), bus.mem_wdata,     vecs[i].e_wdata);
            check($sformatf("v%0d done", i),      32'({bus.r1_done, bus.r0_done}), 32'(vecs[i].e_done));
            check($sformatf("v%0d err", i),       32'({bus.r1_err, bus.r0_err}),   32'(vecs[i].e_err));
            check($sformatf("v%0d rdata", i),     bus.rdata,         vecs[i].e_rdata);
        end

        // Wait states: r1 write, ready on the 6th ACCESS cycle
        do_access(1'b1, 1'b1, 32'h200, 32'h12345678, 6, 32'hBAD0BAD0,
                  n_req, n_done, n_err, n_other, n_bad);
        check("wait mem_req cycles", 32'(n_req), 32'd6);
        check("wait r1_done pulses", 32'(n_done), 32'd1);
        check("wait r1_err pulses",  32'(n_err), 32'd0);
        check("wait other pulses",   32'(n_other), 32'd0);
        check("wait hold stable",    32'(n_bad), 32'd0);
        check("wait rdata kept",     bus.rdata, 32'h33333333);

        // Timeout: memory never answers
        do_access(1'b0, 1'b0, 32'h40, 32'h0, 0, 32'h44444444,
                  n_req, n_done, n_err, n_other, n_bad);
        check("tmo mem_req cycles", 32'(n_req), 32'd8);
        check("tmo r0_err pulses",  32'(n_err), 32'd1);
        check("tmo r0_done pulses", 32'(n_done), 32'd0);
        check("tmo other pulses",   32'(n_other), 32'd0);
        check("tmo rdata kept",     bus.rdata, 32'h33333333);

        // Ready on the limit cycle: completion wins over timeout
        do_access(1'b0, 1'b0, 32'h44, 32'h0, 8, 32'h55555555,
                  n_req, n_done, n_err, n_other, n_bad);
        check("lim mem_req cycles", 32'(n_req), 32'd8);
        check("lim r0_done pulses", 32'(n_done), 32'd1);
        check("lim r0_err pulses",  32'(n_err), 32'd0);
        check("lim rdata",          bus.rdata, 32'h55555555);

        // Withdrawal: r0 drops req one cycle into ACCESS, r1 pending
        clear_inputs();
        bus.r0_req = 1'b1; bus.r0_we = 1'b1; bus.r0_addr = 32'h60; bus.r0_wdata = 32'h66;
        step();
        check("wd gnt r0",    32'(bus.gnt_id),  32'h0);
        check("wd mem_req",   32'(bus.mem_req), 32'h1);
        bus.r0_req = 1'b0;
        bus.r1_req = 1'b1; bus.r1_we = 1'b0; bus.r1_addr = 32'h70;
        step();
        check("wd still access", 32'(bus.mem_req), 32'h1);
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h77;
        step();
        bus.mem_ready = 1'b0;
        check("wd r0_done",   32'(bus.r0_done), 32'h1);
        check("wd rdata kept write", bus.rdata, 32'h55555555);
        step();
        check("wd idle busy", 32'(bus.busy), 32'h0);
        step();
        check("wd gnt r1",    32'(bus.gnt_id),  32'h1);
        check("wd r1 addr",   bus.mem_addr,     32'h70);
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h77777777;
        step();
        bus.mem_ready = 1'b0;
        bus.r1_req = 1'b0;
        check("wd r1_done",   32'(bus.r1_done), 32'h1);
        check("wd r1 rdata",  bus.rdata,        32'h77777777);
        step();

        // Asynchronous reset mid-access, then tie goes to r0
        reset_mid(1'b1);
        reset_mid(1'b0);
        clear_inputs();
        check("post-rst rdata", bus.rdata, 32'h0);
        bus.r0_req = 1'b1; bus.r1_req = 1'b1;
        step();
        check("post-rst tie gnt", 32'(bus.gnt_id), 32'h0);
        check("post-rst busy",    32'(bus.busy),   32'h1);
        bus.mem_ready = 1'b1;
        step();
        clear_inputs();
        check("post-rst r0_done", 32'(bus.r0_done), 32'h1);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mem_port_arbiter
`default_nettype wire
